// File: rtl/cht_seq_pkg.sv
// Shared types and widths for the cht load/shift sequencer.
// Opcodes, FSM states and datapath widths.
package cht_seq_pkg;

    localparam int A_W   = 6;
    localparam int B_W   = 14;
    localparam int C_W   = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'd0,
        CMD_LOAD_A  = 2'd1,
        CMD_SHIFT_B = 2'd2,
        CMD_SHIFT_C = 2'd3
    } cht_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT_B = 2'd1,
        ST_SHIFT_C = 2'd2
    } cht_state_e;

endpackage

// File: rtl/cht_shift_chain.sv
// Serial shift chain: shifts toward bit 0, new bit enters at the MSB.
// Synchronous clear takes priority over the shift enable.
module cht_shift_chain #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sin,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sout
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {sin, q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/cht_shift_sequencer.sv
// Command sequencer owning register A and shift chains B and C.
// One command at a time; multi-cycle shifts run off a down-counter.
module cht_shift_sequencer #(
    parameter int A_W   = cht_seq_pkg::A_W,
    parameter int B_W   = cht_seq_pkg::B_W,
    parameter int C_W   = cht_seq_pkg::C_W,
    parameter int CNT_W = cht_seq_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [A_W-1:0]   cmd_data,
    input  logic             b_sin,
    input  logic             c_sin,
    output logic [A_W-1:0]   a_q,
    output logic [B_W-1:0]   b_q,
    output logic [C_W-1:0]   c_q,
    output logic             b_sout,
    output logic             c_sout,
    output logic             busy,
    output logic             done
);

    import cht_seq_pkg::*;

    cht_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [A_W-1:0]   a_d;
    logic             done_q, done_d;
    logic             b_en, c_en;
    logic             accept;

    assign cmd_ready = (state_q == ST_IDLE) && !clr;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        done_d  = 1'b0;
        b_en    = 1'b0;
        c_en    = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            a_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (cht_op_e'(cmd_op))
                            CMD_NOP: done_d = 1'b1;
                            CMD_LOAD_A: begin
                                a_d    = cmd_data;
                                done_d = 1'b1;
                            end
                            CMD_SHIFT_B, CMD_SHIFT_C: begin
                                if (cmd_cnt == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    cnt_d   = cmd_cnt;
                                    state_d = (cht_op_e'(cmd_op) == CMD_SHIFT_B)
                                            ? ST_SHIFT_B : ST_SHIFT_C;
                                end
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
                ST_SHIFT_B, ST_SHIFT_C: begin
                    b_en  = (state_q == ST_SHIFT_B);
                    c_en  = (state_q == ST_SHIFT_C);
                    cnt_d = cnt_q - 1'b1;
                    // Last shift edge: report done alongside the final chain value
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    cht_shift_chain #(.W(B_W)) u_chain_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (b_en),
        .sin   (b_sin),
        .clr   (clr),
        .q     (b_q),
        .sout  (b_sout)
    );

    cht_shift_chain #(.W(C_W)) u_chain_c (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (c_en),
        .sin   (c_sin),
        .clr   (clr),
        .q     (c_q),
        .sout  (c_sout)
    );

endmodule

// File: tb/tb_cht_shift_sequencer.sv
// Self-checking bench for cht_shift_sequencer.
// Reference model tracks A/B/C as plain values updated per command.
module tb_cht_shift_sequencer;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_SB   = 2'd2;
    localparam logic [1:0] OP_SC   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_cnt = 5'd0;
    logic [5:0]  cmd_data = 6'd0;
    logic        b_sin = 1'b0;
    logic        c_sin = 1'b0;
    logic [5:0]  a_q;
    logic [13:0] b_q;
    logic [15:0] c_q;
    logic        b_sout, c_sout, busy, done;

    int tests_run = 0;
    int fails = 0;

    logic [5:0]  m_a;
    logic [13:0] m_b;
    logic [15:0] m_c;

    always #5 clk = ~clk;

    cht_shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .b_sin     (b_sin),
        .c_sin     (c_sin),
        .a_q       (a_q),
        .b_q       (b_q),
        .c_q       (c_q),
        .b_sout    (b_sout),
        .c_sout    (c_sout),
        .busy      (busy),
        .done      (done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, let it be accepted.
    task automatic send(input logic [1:0] op, input logic [4:0] cnt,
                        input logic [5:0] data, output bit ok);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        while (!cmd_ready && k < 100) begin
            step();
            k++;
        end
        if (!cmd_ready) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
        ok = 1'b1;
        if (op == OP_LOAD) m_a = data;
    endtask

    // Run a shift command; sel_bits[i] is the serial bit for shift edge i.
    task automatic run_shift(input logic [1:0] op, input logic [4:0] n,
                             input logic [31:0] sel_bits, input string tag);
        bit ok;
        bit bad_busy = 1'b0;
        send(op, n, 6'd0, ok);
        if (!ok) return;
        for (int i = 0; i < int'(n); i++) begin
            if (!busy || cmd_ready || done) bad_busy = 1'b1;
            if (op == OP_SB) begin
                b_sin = sel_bits[i];
                c_sin = 1'($urandom);
            end else begin
                c_sin = sel_bits[i];
                b_sin = 1'($urandom);
            end
            step();
            if (op == OP_SB)
                m_b = (m_b >> 1) | (14'(sel_bits[i]) << 13);
            else
                m_c = (m_c >> 1) | (16'(sel_bits[i]) << 15);
        end
        tests_run++;
        if (bad_busy) begin
            fails++;
            $display("FAIL %s_busy: busy/ready/done wrong during shift, required busy=1 ready=0 done=0", tag);
        end
        tests_run++;
        if ({done, busy, cmd_ready} !== 3'b101) begin
            fails++;
            $display("FAIL %s_done: done,busy,ready=%b required 101", tag, {done, busy, cmd_ready});
        end
        tests_run++;
        if ({a_q, b_q, c_q} !== {m_a, m_b, m_c}) begin
            fails++;
            $display("FAIL %s_regs: a=%h b=%h c=%h required a=%h b=%h c=%h",
                     tag, a_q, b_q, c_q, m_a, m_b, m_c);
        end
        tests_run++;
        if ({b_sout, c_sout} !== {m_b[0], m_c[0]}) begin
            fails++;
            $display("FAIL %s_sout: b_sout,c_sout=%b required %b", tag,
                     {b_sout, c_sout}, {m_b[0], m_c[0]});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({a_q, b_q, c_q, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_held: a=%h b=%h c=%h busy=%b done=%b required all 0",
                     a_q, b_q, c_q, busy, done);
        end
        rst_n = 1'b1;
        step();
        m_a = '0; m_b = '0; m_c = '0;
        tests_run++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_idle: ready,busy,done=%b required 100", {cmd_ready, busy, done});
        end
    endtask

    task automatic test_load;
        bit ok;
        send(OP_LOAD, 5'd0, 6'h2D, ok);
        tests_run++;
        if ({done, a_q, b_q, c_q} !== {1'b1, 6'h2D, m_b, m_c}) begin
            fails++;
            $display("FAIL load_a: done=%b a=%h b=%h c=%h required done=1 a=2d b=%h c=%h",
                     done, a_q, b_q, c_q, m_b, m_c);
        end
        step();
        tests_run++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL load_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_shift_b;
        run_shift(OP_SB, 5'd4, 32'b1101, "shift_b4");
        tests_run++;
        if (b_q !== 14'b11010000000000) begin
            fails++;
            $display("FAIL shift_b4_value: b=%b required 11010000000000", b_q);
        end
        step();
    endtask

    task automatic test_shift_c_long;
        run_shift(OP_SC, 5'd20, 32'hFFFF_FFFF, "shift_c20");
        tests_run++;
        if ({c_q, c_sout} !== {16'hFFFF, 1'b1}) begin
            fails++;
            $display("FAIL shift_c20_value: c=%h c_sout=%b required ffff 1", c_q, c_sout);
        end
        step();
    endtask

    task automatic test_clr_abort;
        bit ok;
        bit saw_done = 1'b0;
        send(OP_SC, 5'd10, 6'd0, ok);
        if (!ok) return;
        repeat (2) begin
            c_sin = 1'($urandom);
            step();
        end
        clr       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_SB;
        cmd_cnt   = 5'd5;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_ready: cmd_ready=%b required 0", cmd_ready);
        end
        step();
        clr = 1'b0;
        cmd_valid = 1'b0;
        m_a = '0; m_b = '0; m_c = '0;
        tests_run++;
        if ({a_q, b_q, c_q, busy, done} !== '0) begin
            fails++;
            $display("FAIL clr_state: a=%h b=%h c=%h busy=%b done=%b required all 0",
                     a_q, b_q, c_q, busy, done);
        end
        repeat (12) begin
            b_sin = 1'b1;
            c_sin = 1'b1;
            step();
            if (done || busy) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done || b_q !== 14'd0 || c_q !== 16'd0) begin
            fails++;
            $display("FAIL clr_abort: stray activity b=%h c=%h required b=0 c=0 no done/busy", b_q, c_q);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [2:0] d;
        m_b = 14'h2A5A & 14'h3FFF;
        run_shift(OP_SB, 5'd14, 32'h00002A5A, "b2b_setup");
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD; cmd_data = 6'h15; cmd_cnt = 5'd0;
        step();
        m_a = 6'h15;
        d[0] = done;
        cmd_op = OP_SB; cmd_cnt = 5'd0;
        step();
        d[1] = done;
        cmd_op = OP_NOP;
        step();
        d[2] = done;
        cmd_valid = 1'b0;
        tests_run++;
        if (d !== 3'b111) begin
            fails++;
            $display("FAIL b2b_done: done history=%b required 111", d);
        end
        tests_run++;
        if ({a_q, b_q, c_q} !== {m_a, m_b, m_c}) begin
            fails++;
            $display("FAIL b2b_regs: a=%h b=%h c=%h required a=%h b=%h c=%h",
                     a_q, b_q, c_q, m_a, m_b, m_c);
        end
        step();
        tests_run++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done_drop: done=%b required 0", done);
        end
        send(OP_SC, 5'd0, 6'd0, ok);
        tests_run++;
        if ({done, busy, c_q} !== {1'b1, 1'b0, m_c}) begin
            fails++;
            $display("FAIL cnt0_shift: done=%b busy=%b c=%h required 1 0 %h", done, busy, c_q, m_c);
        end
        step();
    endtask

    task automatic test_async_reset;
        bit ok;
        send(OP_SB, 5'd8, 6'd0, ok);
        if (!ok) return;
        repeat (2) begin
            b_sin = 1'b1;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a_q, b_q, c_q, busy, done} !== '0) begin
            fails++;
            $display("FAIL async_reset: a=%h b=%h c=%h busy=%b done=%b required all 0",
                     a_q, b_q, c_q, busy, done);
        end
        step();
        rst_n = 1'b1;
        m_a = '0; m_b = '0; m_c = '0;
        repeat (8) step();
        tests_run++;
        if ({done, busy, cmd_ready, b_q} !== {3'b001, 14'd0}) begin
            fails++;
            $display("FAIL async_reset_idle: done=%b busy=%b ready=%b b=%h required 0 0 1 0",
                     done, busy, cmd_ready, b_q);
        end
    endtask

    task automatic test_random;
        bit ok;
        for (int t = 0; t < 40; t++) begin
            logic [1:0] op;
            op = 2'($urandom);
            if (op == OP_SB || op == OP_SC) begin
                run_shift(op, 5'($urandom_range(0, 31)), $urandom, "rand_shift");
            end else begin
                send(op, 5'($urandom), 6'($urandom), ok);
                tests_run++;
                if ({done, a_q, b_q, c_q} !== {1'b1, m_a, m_b, m_c}) begin
                    fails++;
                    $display("FAIL rand_cmd: op=%0d done=%b a=%h b=%h c=%h required 1 %h %h %h",
                             op, done, a_q, b_q, c_q, m_a, m_b, m_c);
                end
            end
            step();
            tests_run++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL rand_done_drop: done=%b required 0", done);
            end
        end
    endtask

    initial begin
        m_a = '0; m_b = '0; m_c = '0;
        test_reset();
        test_load();
        test_shift_b();
        test_shift_c_long();
        test_clr_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
